// File: rtl/seg_pkg.sv
// Shared constants for the intersection display stage:
// light codes, glyphs, anode patterns and small helper types.
package seg_pkg;

    localparam logic [1:0] L_OFF   = 2'd0;
    localparam logic [1:0] L_GREEN = 2'd1;
    localparam logic [1:0] L_YEL   = 2'd2;
    localparam logic [1:0] L_RED   = 2'd3;

    localparam logic [6:0] G_OFF   = 7'b1111111;
    localparam logic [6:0] G_GREEN = 7'b0100001;
    localparam logic [6:0] G_YEL   = 7'b1000100;
    localparam logic [6:0] G_RED   = 7'b1111010;
    localparam logic [6:0] G_WALK  = 7'b0011000;

    localparam logic [6:0] ALL_DARK = 7'b1111111;

    localparam logic [3:0] AN_D3   = 4'b0111;
    localparam logic [3:0] AN_D2   = 4'b1011;
    localparam logic [3:0] AN_D1   = 4'b1101;
    localparam logic [3:0] AN_D0   = 4'b1110;
    localparam logic [3:0] AN_DARK = 4'b1111;

    typedef enum logic [1:0] {
        K_BLANK,
        K_LIGHT,
        K_DIGIT,
        K_WALK
    } seg_kind_e;

    typedef enum logic {
        S_BLANK,
        S_SHOW
    } scan_state_e;

    function automatic logic [3:0] anode_of(input logic [1:0] idx);
        logic [3:0] an;
        unique case (idx)
            2'd3: an = AN_D3;
            2'd2: an = AN_D2;
            2'd1: an = AN_D1;
            default: an = AN_D0;
        endcase
        return an;
    endfunction

endpackage

// File: rtl/seg_decode.sv
// Combinational glyph lookup: a light code, a decimal digit,
// the walk glyph, or blank, as active-low abcdefg segments.
module seg_decode
    import seg_pkg::*;
(
    input  seg_kind_e  kind,
    input  logic [3:0] value,
    output logic [6:0] glyph
);

    always_comb begin
        glyph = G_OFF;
        unique case (kind)
            K_LIGHT: begin
                unique case (value[1:0])
                    L_GREEN: glyph = G_GREEN;
                    L_YEL:   glyph = G_YEL;
                    L_RED:   glyph = G_RED;
                    default: glyph = G_OFF;
                endcase
            end
            K_DIGIT: begin
                case (value)
                    4'd0: glyph = 7'b0000001;
                    4'd1: glyph = 7'b1001111;
                    4'd2: glyph = 7'b0010010;
                    4'd3: glyph = 7'b0000110;
                    4'd4: glyph = 7'b1001100;
                    4'd5: glyph = 7'b0100100;
                    4'd6: glyph = 7'b0100000;
                    4'd7: glyph = 7'b0001111;
                    4'd8: glyph = 7'b0000000;
                    4'd9: glyph = 7'b0000100;
                    default: glyph = G_OFF;
                endcase
            end
            K_WALK:  glyph = G_WALK;
            default: glyph = G_OFF;
        endcase
    end

endmodule

// File: rtl/light_scan_display.sv
// Four-digit multiplexed display of the intersection state with
// inter-digit blanking, per-frame input snapshot and yellow blink.
module light_scan_display
    import seg_pkg::*;
#(
    parameter int DWELL        = 1,
    parameter int BLANK_CYCLES = 1,
    parameter int BLINK_DIV    = 250
) (
    input  logic       clk_out_2,
    input  logic       reset,
    input  logic [1:0] main_light,
    input  logic [1:0] side_light,
    input  logic       walk_light,
    input  logic [3:0] remain,
    output logic [6:0] to_seg,
    output logic [3:0] lights_on
);

    localparam int MAXC = (DWELL > BLANK_CYCLES) ? DWELL : BLANK_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int BW   = $clog2(BLINK_DIV);

    scan_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          phase_q, phase_d;
    logic [1:0]    main_q, main_d;
    logic [1:0]    side_q, side_d;
    logic          walk_q, walk_d;
    logic [3:0]    remain_q, remain_d;
    logic          ph_q, ph_d;
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    an_q, an_d;

    seg_kind_e     kind;
    logic [3:0]    value;
    logic [6:0]    glyph;
    logic [1:0]    light;

    seg_decode u_dec (
        .kind  (kind),
        .value (value),
        .glyph (glyph)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        blink_cnt_d = blink_cnt_q + 1'b1;
        phase_d     = phase_q;
        main_d      = main_q;
        side_d      = side_q;
        walk_d      = walk_q;
        remain_d    = remain_q;
        ph_d        = ph_q;

        if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end

        unique case (state_q)
            S_BLANK: begin
                if (cnt_q == CW'(BLANK_CYCLES - 1)) begin
                    cnt_d   = '0;
                    idx_d   = idx_q - 2'd1;
                    state_d = S_SHOW;
                    // Frame start: snapshot with the pre-toggle blink phase.
                    if (idx_q == 2'd0) begin
                        main_d   = main_light;
                        side_d   = side_light;
                        walk_d   = walk_light;
                        remain_d = remain;
                        ph_d     = phase_q;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                if (cnt_q == CW'(DWELL - 1)) begin
                    cnt_d   = '0;
                    state_d = S_BLANK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        kind  = K_BLANK;
        value = '0;
        light = L_OFF;
        unique case (idx_d)
            2'd3: light = main_d;
            2'd0: light = side_d;
            default: light = L_OFF;
        endcase
        unique case (idx_d)
            2'd2: begin
                kind  = (remain_d >= 4'd10) ? K_DIGIT : K_BLANK;
                value = 4'd1;
            end
            2'd1: begin
                kind  = K_DIGIT;
                value = (remain_d >= 4'd10) ? remain_d - 4'd10 : remain_d;
            end
            default: begin
                kind  = (light == L_YEL && !ph_d) ? K_BLANK : K_LIGHT;
                value = {2'b00, light};
                if (idx_d == 2'd0 && walk_d) begin
                    kind = K_WALK;
                end
            end
        endcase
        seg_d = (state_d == S_SHOW) ? glyph : ALL_DARK;
        an_d  = (state_d == S_SHOW) ? anode_of(idx_d) : AN_DARK;
    end

    always_ff @(posedge clk_out_2) begin
        if (reset) begin
            state_q     <= S_BLANK;
            cnt_q       <= '0;
            idx_q       <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b1;
            main_q      <= '0;
            side_q      <= '0;
            walk_q      <= 1'b0;
            remain_q    <= '0;
            ph_q        <= 1'b0;
            seg_q       <= ALL_DARK;
            an_q        <= AN_DARK;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            main_q      <= main_d;
            side_q      <= side_d;
            walk_q      <= walk_d;
            remain_q    <= remain_d;
            ph_q        <= ph_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
        end
    end

    assign to_seg    = seg_q;
    assign lights_on = an_q;

endmodule

// File: tb/tb_light_scan_display.sv
// Directed frame-by-frame checks of the multiplexed display,
// including blink, mid-frame input change and mid-frame reset.
module tb_light_scan_display;

    logic       clk_out_2 = 1'b0;
    logic       reset;
    logic [1:0] main_light;
    logic [1:0] side_light;
    logic       walk_light;
    logic [3:0] remain;
    logic [6:0] to_seg;
    logic [3:0] lights_on;
    logic [6:0] to_seg_b;
    logic [3:0] lights_on_b;

    int errors = 0;
    int checks = 0;

    localparam logic [6:0] D   = 7'b1111111;
    localparam logic [6:0] GG  = 7'b0100001;
    localparam logic [6:0] GY  = 7'b1000100;
    localparam logic [6:0] GR  = 7'b1111010;
    localparam logic [6:0] GP  = 7'b0011000;
    localparam logic [6:0] N0  = 7'b0000001;
    localparam logic [6:0] N1  = 7'b1001111;
    localparam logic [6:0] N2  = 7'b0010010;
    localparam logic [6:0] N5  = 7'b0100100;
    localparam logic [6:0] N7  = 7'b0001111;
    localparam logic [6:0] N9  = 7'b0000100;

    typedef struct {
        logic [1:0] m;
        logic [1:0] s;
        logic       w;
        logic [3:0] r;
        logic [6:0] g3;
        logic [6:0] g2;
        logic [6:0] g1;
        logic [6:0] g0;
    } vec_t;

    vec_t vecs [6];

    always #5 clk_out_2 = ~clk_out_2;

    light_scan_display dut (
        .clk_out_2  (clk_out_2),
        .reset      (reset),
        .main_light (main_light),
        .side_light (side_light),
        .walk_light (walk_light),
        .remain     (remain),
        .to_seg     (to_seg),
        .lights_on  (lights_on)
    );

    light_scan_display #(
        .DWELL        (2),
        .BLANK_CYCLES (1),
        .BLINK_DIV    (4)
    ) dut_b (
        .clk_out_2  (clk_out_2),
        .reset      (reset),
        .main_light (main_light),
        .side_light (side_light),
        .walk_light (walk_light),
        .remain     (remain),
        .to_seg     (to_seg_b),
        .lights_on  (lights_on_b)
    );

    task automatic tick;
        @(posedge clk_out_2);
        #1;
    endtask

    task automatic chk(input string nm, input logic [3:0] an,
                       input logic [6:0] sg, input logic [3:0] ean,
                       input logic [6:0] esg);
        checks++;
        if (an !== ean || sg !== esg) begin
            errors++;
            $display("FAIL %s: got an=%b seg=%b, want an=%b seg=%b",
                     nm, an, sg, ean, esg);
        end
    endtask

    task automatic set_in(input logic [1:0] m, input logic [1:0] s,
                          input logic w, input logic [3:0] r);
        main_light = m;
        side_light = s;
        walk_light = w;
        remain     = r;
    endtask

    // Default-parameter frame: ticks k=0..7, even k lit, odd k dark.
    task automatic run_frame(input string nm, input logic [6:0] g3,
                             input logic [6:0] g2, input logic [6:0] g1,
                             input logic [6:0] g0, input int k0,
                             input int k1);
        for (int k = k0; k <= k1; k++) begin
            tick();
            if (k % 2 == 1) begin
                chk(nm, lights_on, to_seg, 4'b1111, D);
            end else begin
                case (k / 2)
                    0: chk(nm, lights_on, to_seg, 4'b0111, g3);
                    1: chk(nm, lights_on, to_seg, 4'b1011, g2);
                    2: chk(nm, lights_on, to_seg, 4'b1101, g1);
                    default: chk(nm, lights_on, to_seg, 4'b1110, g0);
                endcase
            end
        end
    endtask

    // DWELL=2 frame on dut_b: each digit lit two ticks then one dark.
    task automatic run_frame_b(input string nm, input logic [6:0] g3,
                               input logic [6:0] g2, input logic [6:0] g1,
                               input logic [6:0] g0);
        for (int k = 0; k < 12; k++) begin
            tick();
            if (k % 3 == 2) begin
                chk(nm, lights_on_b, to_seg_b, 4'b1111, D);
            end else begin
                case (k / 3)
                    0: chk(nm, lights_on_b, to_seg_b, 4'b0111, g3);
                    1: chk(nm, lights_on_b, to_seg_b, 4'b1011, g2);
                    2: chk(nm, lights_on_b, to_seg_b, 4'b1101, g1);
                    default: chk(nm, lights_on_b, to_seg_b, 4'b1110, g0);
                endcase
            end
        end
    endtask

    initial begin
        vecs[0] = '{2'd1, 2'd3, 1'b0, 4'd7,  GG, D,  N7, GR};
        vecs[1] = '{2'd3, 2'd1, 1'b0, 4'd12, GR, N1, N2, GG};
        vecs[2] = '{2'd0, 2'd2, 1'b0, 4'd0,  D,  D,  N0, GY};
        vecs[3] = '{2'd2, 2'd0, 1'b1, 4'd15, GY, N1, N5, GP};
        vecs[4] = '{2'd3, 2'd1, 1'b1, 4'd10, GR, N1, N0, GP};
        vecs[5] = '{2'd1, 2'd1, 1'b0, 4'd9,  GG, D,  N9, GG};

        reset = 1'b1;
        set_in(2'd1, 2'd3, 1'b0, 4'd7);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("reset", lights_on, to_seg, 4'b1111, D);
            chk("reset_b", lights_on_b, to_seg_b, 4'b1111, D);
        end
        reset = 1'b0;

        for (int v = 0; v < 6; v++) begin
            set_in(vecs[v].m, vecs[v].s, vecs[v].w, vecs[v].r);
            run_frame($sformatf("vec%0d", v), vecs[v].g3, vecs[v].g2,
                      vecs[v].g1, vecs[v].g0, 0, 7);
        end

        set_in(2'd1, 2'd3, 1'b0, 4'd7);
        run_frame("midchg_pre", GG, D, N7, GR, 0, 4);
        main_light = 2'd3;
        run_frame("midchg_rest", GG, D, N7, GR, 5, 7);
        run_frame("midchg_next", GR, D, N7, GR, 0, 7);

        run_frame("rst_pre", GR, D, N7, GR, 0, 2);
        reset = 1'b1;
        tick();
        chk("rst_dark", lights_on, to_seg, 4'b1111, D);
        reset = 1'b0;
        run_frame("rst_restart", GR, D, N7, GR, 0, 7);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_in(2'd2, 2'd3, 1'b0, 4'd5);
        run_frame_b("blink_f0", GY, D, N5, GR);
        run_frame_b("blink_f1", D,  D, N5, GR);
        run_frame_b("blink_f2", GY, D, N5, GR);
        run_frame_b("blink_f3", D,  D, N5, GR);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/light_scan_display.md
# light_scan_display

Downstream display stage of the intersection controller: consumes the controller's main/side light codes, walk lamp and remaining-phase seconds, and time-multiplexes them onto the 4-digit common-anode seven-segment display. Adds anti-ghosting blanking between digits, frame-coherent input sampling, leading-zero suppression and a blinking yellow glyph. Runs entirely in the display refresh domain.

## Interface
- DWELL, 1: clk_out_2 cycles each digit is lit (>=1).
- BLANK_CYCLES, 1: all-dark cycles between digits (>=1).
- BLINK_DIV, 250: clk_out_2 cycles per blink half-period (>=2).
- clk_out_2  in  1  display refresh clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high; sampled on clk_out_2.
- main_light  in  2  0 off, 1 green, 2 yellow, 3 red.
- side_light  in  2  same encoding.
- walk_light  in  1  pedestrian phase active.
- remain  in  4  seconds left in current phase, 0-15.
- to_seg  out  7  active-low segments, bit6=a … bit0=g.
- lights_on  out  4  active-low anodes; bit3 leftmost.

## Operation
- Digit map: d3 (lights_on 4'b0111) main glyph; d2 (4'b1011) remain tens; d1 (4'b1101) remain units; d0 (4'b1110) side glyph.
- Glyphs: off 7'b1111111; green 'G' 7'b0100001; yellow 'Y' 7'b1000100; red 'r' 7'b1111010; walk 'P' 7'b0011000; digits 0-9 standard active-low (0 = 7'b0000001, 1 = 7'b1001111, 2 = 7'b0010010, 7 = 7'b0001111).
- Tens: remain>=10 shows '1', else blank (leading-zero suppression). Units: remain mod 10.
- walk_light=1 overrides d0 with 'P' regardless of side_light.
- Yellow blink: free-running counter 0..BLINK_DIV-1; phase toggles on wrap. A yellow glyph shows 'Y' when phase=1, blank when phase=0. Other codes never blink.
- Shadow registers capture main_light, side_light, walk_light, remain and blink phase only on entry to d3 (frame start). All four digits of one frame show the same snapshot.
- FSM: BLANK, SHOW. Counter cnt, digit index idx (3..0).
  - BLANK: outputs dark (lights_on 4'b1111, to_seg 7'b1111111). When cnt==BLANK_CYCLES-1: cnt<=0, idx<=idx-1 (0 wraps to 3), go SHOW; on wrap to 3, shadows load in the same edge.
  - SHOW: drive idx digit. When cnt==DWELL-1: cnt<=0, go BLANK.
- Reset: state BLANK, idx 0, cnt 0, blink counter 0, phase 1, shadows 0, lights_on 4'b1111, to_seg 7'b1111111.

## Timing
- Outputs registered; they change only on clk_out_2 edges, together with state.
- First edge with reset low and BLANK_CYCLES=1: SHOW d3 from inputs sampled at that edge.
- Frame = 4·(DWELL+BLANK_CYCLES) cycles (8 at defaults); input-to-display latency <= one frame + 1 cycle.
- Never two anodes low at once; every anode transition passes through >=BLANK_CYCLES dark cycles.
- Input changes mid-frame are ignored until next d3 entry. A blink wrap on the same edge as shadow load captures the pre-toggle phase.
- reset mid-frame: outputs dark on that edge, sequence restarts as after power-up.
- remain is 4 bits; no saturation needed (max display 15).

## Structure
- Package seg_pkg: light code constants (L_OFF, L_GREEN, L_YEL, L_RED), glyph constants, anode patterns per digit, ALL_DARK.
- Sub-module seg_decode: combinational {kind, value} -> 7-bit glyph (light glyph or decimal digit); instantiated once on the selected digit.
- Top holds FSM, counters, blink generator, shadow registers, output registers.

## Test plan
- Reset held 3 cycles -> lights_on 4'b1111, to_seg 7'b1111111 throughout; first SHOW is d3 on first edge after release.
- main=1, side=3, walk=0, remain=7, defaults -> per frame: 4'b0111/0100001, dark, 4'b1011/1111111, dark, 4'b1101/0001111, dark, 4'b1110/1111010, dark.
- remain=12 -> d2 '1' (7'b1001111), d1 '2' (7'b0010010); remain=0 -> d2 blank, d1 7'b0000001.
- walk=1, side=1 -> d0 shows 7'b0011000.
- BLINK_DIV=4, main=2 -> d3 alternates 'Y' and blank across frames per sampled phase; side=3 stays 'r'.
- Change main 1->3 while d1 lit -> rest of frame unchanged, next d3 shows 'r'; assert reset during d2 -> dark next edge, restart from d3.
